// File: rtl/device_info_write_arbiter.sv
// -----------------------------------------------------------------------------
// device_info_write_arbiter
//
// Shares one single-beat device-info write master among NUM_REQ requesters.
// A round-robin arbiter picks one {address, info word} request at a time,
// latches it, pulses the write master's start, and waits for its done pulse.
// The granted requester then receives a one-cycle completion pulse. A sticky
// watchdog flag reports a write master that stays silent too long.
//
// Ports:
//   aclk, areset      clock, asynchronous active-high reset
//   req_valid[i]      request from requester i, held until req_ready[i]
//   req_ready[i]      one-hot accept (combinational, only in idle)
//   req_addr/req_data packed per-requester address / info word
//   req_done[i]       one-cycle completion pulse to the granted requester
//   wm_start          one-cycle start pulse to the write master
//   wm_addr/wm_data   latched request, stable until the write master is done
//   wm_done           write master completion pulse
//   busy              transaction in flight (start or wait)
//   grant_id          index of the current / last granted requester
//   err_timeout       sticky watchdog flag
// -----------------------------------------------------------------------------
module device_info_write_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_W         = 64,
  parameter int DATA_W         = 512,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         req_done,
  output logic                       wm_start,
  output logic [ADDR_W-1:0]          wm_addr,
  output logic [DATA_W-1:0]          wm_data,
  input  logic                       wm_done,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       err_timeout
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT} state_t;

  state_t              state_q, state_d;
  logic [GW-1:0]       last_q, last_d;
  logic [GW-1:0]       grant_q, grant_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                err_q, err_d;
  logic [NUM_REQ-1:0]  done_q, done_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;

  logic                win_found;
  logic [GW-1:0]       win_idx;
  logic [GW:0]         cand;

  // Round-robin search starting just after the last completed grant. The
  // candidate index is computed one bit wider so the wrap is a single subtract.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = {1'b0, last_q} + (GW+1)'(off);
      if (cand >= (GW+1)'(NUM_REQ)) begin
        cand = cand - (GW+1)'(NUM_REQ);
      end
      if (!win_found && req_valid[cand[GW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[GW-1:0];
      end
    end
  end

  // Accept is gated by reset so every output reads zero while areset is high.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
    assign req_ready[gi] = ~areset & (state_q == S_IDLE) & win_found &
                           (win_idx == GW'(gi));
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    done_d  = '0;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          addr_d  = req_addr[win_idx*ADDR_W +: ADDR_W];
          data_d  = req_data[win_idx*DATA_W +: DATA_W];
          grant_d = win_idx;
          state_d = S_START;
        end
      end
      S_START: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q != CW'(TIMEOUT_CYCLES)) begin
          cnt_d = cnt_q + 1'b1;
        end
        // Flag on the cycle the counter reaches the limit; the wait goes on.
        if (cnt_q >= CW'(TIMEOUT_CYCLES - 1)) begin
          err_d = 1'b1;
        end
        if (wm_done) begin
          done_d[grant_q] = 1'b1;
          last_d          = grant_q;
          state_d         = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= S_IDLE;
      last_q  <= GW'(NUM_REQ - 1);
      grant_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      done_q  <= done_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign wm_start    = (state_q == S_START);
  assign busy        = (state_q != S_IDLE);
  assign wm_addr     = addr_q;
  assign wm_data     = data_q;
  assign grant_id    = grant_q;
  assign err_timeout = err_q;
  assign req_done    = done_q;

  // A requester must keep req_valid up while it is being accepted.
  a_ready_implies_valid: assert property (@(posedge aclk) disable iff (areset)
    ((req_ready & ~req_valid) == '0));

endmodule

// File: tb/tb_device_info_write_arbiter.sv
module tb_device_info_write_arbiter;
  localparam int N  = 4;
  localparam int AW = 64;
  localparam int DW = 512;
  localparam int TO = 16;

  logic            aclk = 1'b0;
  logic            areset;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_done;
  logic            wm_start;
  logic [AW-1:0]   wm_addr;
  logic [DW-1:0]   wm_data;
  logic            wm_done;
  logic            busy;
  logic [1:0]      grant_id;
  logic            err_timeout;

  device_info_write_arbiter #(
    .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .aclk(aclk), .areset(areset), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .req_done(req_done),
    .wm_start(wm_start), .wm_addr(wm_addr), .wm_data(wm_data),
    .wm_done(wm_done), .busy(busy), .grant_id(grant_id),
    .err_timeout(err_timeout)
  );

  always #5 aclk = ~aclk;

  int total = 0;
  int bad   = 0;
  int m_last;                 // reference round-robin pointer
  logic [AW-1:0] addr_tab [N];
  logic [DW-1:0] data_tab [N];

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic pack_reqs();
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW] = addr_tab[i];
      req_data[i*DW +: DW] = data_tab[i];
    end
  endtask

  task automatic randomize_reqs();
    for (int i = 0; i < N; i++) begin
      addr_tab[i] = {$urandom, $urandom};
      for (int j = 0; j < DW/32; j++) data_tab[i][j*32 +: 32] = $urandom;
    end
    pack_reqs();
  endtask

  task automatic apply_reset();
    areset = 1'b1; req_valid = '0; wm_done = 1'b0;
    tick(); tick();
    areset = 1'b0;
    m_last = N - 1;
  endtask

  // Reference arbitration: first valid requester after the last grant, wrapping.
  function automatic int winner(input int last, input logic [N-1:0] m);
    int idx;
    for (int k = 1; k <= N; k++) begin
      idx = (last + k) % N;
      if (m[idx[1:0]]) return idx;
    end
    return -1;
  endfunction

  task automatic test_reset();
    areset = 1'b1; wm_done = 1'b0;
    randomize_reqs();
    req_valid = 4'hF;
    tick();
    total++; if (req_ready !== 4'h0) begin bad++; $display("FAIL reset_ready got=%b want=0000", req_ready); end
    total++; if (req_done !== 4'h0) begin bad++; $display("FAIL reset_done got=%b want=0000", req_done); end
    total++; if ({wm_start, busy, err_timeout} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {wm_start, busy, err_timeout}); end
    total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL reset_grant got=%0d want=0", grant_id); end
    total++; if (wm_addr !== '0 || wm_data !== '0) begin bad++; $display("FAIL reset_wm got=%h want=0", wm_addr); end
    req_valid = '0;
    areset = 1'b0;
    m_last = N - 1;
    $display("txn reset released");
  endtask

  task automatic test_single();
    addr_tab[1] = 64'h1000;
    data_tab[1] = {64{8'hA5}};
    pack_reqs();
    req_valid = 4'b0010;
    #1;
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL single_ready got=%b want=0010", req_ready); end
    tick();
    req_valid = '0;
    total++; if (wm_start !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL single_start got=%b%b want=11", wm_start, busy); end
    total++; if (wm_addr !== 64'h1000) begin bad++; $display("FAIL single_addr got=%h want=1000", wm_addr); end
    total++; if (wm_data !== {64{8'hA5}}) begin bad++; $display("FAIL single_data got=%h", wm_data); end
    total++; if (grant_id !== 2'd1) begin bad++; $display("FAIL single_grant got=%0d want=1", grant_id); end
    for (int k = 1; k <= 10; k++) begin
      tick();
      total++; if ({busy, wm_start, req_done} !== 6'b100000) begin bad++; $display("FAIL single_wait k=%0d got=%b want=100000", k, {busy, wm_start, req_done}); end
      if (k == 10) wm_done = 1'b1;
    end
    tick();
    wm_done = 1'b0;
    total++; if (req_done !== 4'b0010 || busy !== 1'b0) begin bad++; $display("FAIL single_done got=%b busy=%b want=0010 busy=0", req_done, busy); end
    tick();
    total++; if (req_done !== 4'b0000) begin bad++; $display("FAIL single_done_pulse got=%b want=0000", req_done); end
    m_last = 1;
    $display("txn single grant=1 addr=%h", wm_addr);
  endtask

  task automatic test_random();
    logic [N-1:0] mask;
    int lat;
    int w;
    for (int t = 0; t < 20; t++) begin
      randomize_reqs();
      mask = N'($urandom_range(1, 15));
      lat  = $urandom_range(1, 8);
      w    = winner(m_last, mask);
      req_valid = mask;
      #1;
      total++; if (req_ready !== (4'b1 << w)) begin bad++; $display("FAIL rand_ready t=%0d got=%b want=%b", t, req_ready, 4'b1 << w); end
      tick();
      req_valid = mask & ~(4'b1 << w);
      total++; if (wm_start !== 1'b1 || grant_id !== 2'(w)) begin bad++; $display("FAIL rand_grant t=%0d got=%0d start=%b want=%0d", t, grant_id, wm_start, w); end
      total++; if (wm_addr !== addr_tab[w] || wm_data !== data_tab[w]) begin bad++; $display("FAIL rand_latch t=%0d got=%h want=%h", t, wm_addr, addr_tab[w]); end
      for (int k = 1; k <= lat; k++) begin
        tick();
        total++; if ({busy, wm_start, req_ready, req_done} !== 10'b10_0000_0000) begin bad++; $display("FAIL rand_wait t=%0d k=%0d got=%b", t, k, {busy, wm_start, req_ready, req_done}); end
        if (k == lat) wm_done = 1'b1;
      end
      tick();
      wm_done = 1'b0;
      total++; if (req_done !== (4'b1 << w) || busy !== 1'b0) begin bad++; $display("FAIL rand_done t=%0d got=%b want=%b", t, req_done, 4'b1 << w); end
      m_last = w;
      $display("txn random mask=%b lat=%0d grant=%0d", mask, lat, w);
    end
    req_valid = '0;
  endtask

  task automatic test_spurious();
    int r;
    wm_done = 1'b1;
    tick();
    wm_done = 1'b0;
    total++; if (req_done !== 4'h0 || busy !== 1'b0) begin bad++; $display("FAIL spur_idle got=%b busy=%b want=0000 busy=0", req_done, busy); end
    r = $urandom_range(0, 3);
    randomize_reqs();
    req_valid = 4'b1 << r;
    #1;
    total++; if (req_ready !== (4'b1 << r)) begin bad++; $display("FAIL spur_ready got=%b want=%b", req_ready, 4'b1 << r); end
    tick();
    req_valid = '0;
    wm_done = 1'b1;     // lands while the arbiter is still in start
    tick();
    wm_done = 1'b0;
    total++; if ({busy, wm_start, req_done} !== 6'b100000) begin bad++; $display("FAIL spur_start got=%b want=100000", {busy, wm_start, req_done}); end
    for (int k = 2; k <= 4; k++) begin
      tick();
      total++; if (busy !== 1'b1 || req_done !== 4'h0) begin bad++; $display("FAIL spur_wait k=%0d busy=%b done=%b", k, busy, req_done); end
      if (k == 4) wm_done = 1'b1;
    end
    tick();
    wm_done = 1'b0;
    total++; if (req_done !== (4'b1 << r)) begin bad++; $display("FAIL spur_done got=%b want=%b", req_done, 4'b1 << r); end
    m_last = r;
    $display("txn spurious grant=%0d", r);
  endtask

  task automatic test_handoff();
    randomize_reqs();
    req_valid = 4'b1000;
    #1;
    total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL hand_ready3 got=%b want=1000", req_ready); end
    tick();
    req_valid = '0;
    total++; if (grant_id !== 2'd3 || wm_addr !== addr_tab[3]) begin bad++; $display("FAIL hand_grant3 got=%0d want=3", grant_id); end
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k >= 3) req_valid = 4'b0001;
      #1;
      total++; if (req_ready !== 4'h0) begin bad++; $display("FAIL hand_wait k=%0d got=%b want=0000", k, req_ready); end
      if (k == 6) wm_done = 1'b1;
    end
    tick();
    wm_done = 1'b0;
    total++; if (req_done !== 4'b1000 || req_ready !== 4'b0001) begin bad++; $display("FAIL hand_idle done=%b ready=%b want=1000/0001", req_done, req_ready); end
    tick();
    req_valid = '0;
    total++; if (wm_start !== 1'b1 || grant_id !== 2'd0) begin bad++; $display("FAIL hand_grant0 got=%0d start=%b want=0", grant_id, wm_start); end
    total++; if (wm_addr !== addr_tab[0] || wm_data !== data_tab[0]) begin bad++; $display("FAIL hand_latch0 got=%h want=%h", wm_addr, addr_tab[0]); end
    tick();
    wm_done = 1'b1;
    tick();
    wm_done = 1'b0;
    total++; if (req_done !== 4'b0001) begin bad++; $display("FAIL hand_done0 got=%b want=0001", req_done); end
    m_last = 0;
    $display("txn handoff 3 then 0");
  endtask

  task automatic test_fairness();
    int ord [6] = '{0, 1, 2, 3, 0, 1};
    apply_reset();
    randomize_reqs();
    req_valid = 4'hF;
    #1;
    for (int n = 0; n < 6; n++) begin
      total++; if (req_ready !== (4'b1 << ord[n])) begin bad++; $display("FAIL fair_ready n=%0d got=%b want=%b", n, req_ready, 4'b1 << ord[n]); end
      tick();
      total++; if (grant_id !== 2'(ord[n]) || wm_addr !== addr_tab[ord[n]]) begin bad++; $display("FAIL fair_grant n=%0d got=%0d want=%0d", n, grant_id, ord[n]); end
      for (int k = 1; k <= 5; k++) begin
        tick();
        total++; if (req_ready !== 4'h0 || req_done !== 4'h0) begin bad++; $display("FAIL fair_wait n=%0d k=%0d ready=%b done=%b", n, k, req_ready, req_done); end
        if (k == 5) wm_done = 1'b1;
      end
      tick();
      wm_done = 1'b0;
      total++; if (req_done !== (4'b1 << ord[n])) begin bad++; $display("FAIL fair_done n=%0d got=%b want=%b", n, req_done, 4'b1 << ord[n]); end
      $display("txn fairness grant=%0d", ord[n]);
    end
    req_valid = '0;
    m_last = 1;
  endtask

  task automatic test_watchdog();
    int r;
    apply_reset();
    r = $urandom_range(0, 3);
    randomize_reqs();
    req_valid = 4'b1 << r;
    #1;
    tick();
    req_valid = '0;
    total++; if (wm_start !== 1'b1 || err_timeout !== 1'b0) begin bad++; $display("FAIL wd_start start=%b err=%b want=1/0", wm_start, err_timeout); end
    for (int k = 1; k <= TO; k++) begin
      tick();
      total++; if (err_timeout !== 1'b0) begin bad++; $display("FAIL wd_early k=%0d got=%b want=0", k, err_timeout); end
    end
    tick();
    total++; if (err_timeout !== 1'b1) begin bad++; $display("FAIL wd_rise got=%b want=1", err_timeout); end
    for (int k = 0; k < 4; k++) begin
      tick();
      total++; if (err_timeout !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL wd_hold k=%0d err=%b busy=%b", k, err_timeout, busy); end
      if (k == 3) wm_done = 1'b1;
    end
    tick();
    wm_done = 1'b0;
    total++; if (req_done !== (4'b1 << r) || busy !== 1'b0) begin bad++; $display("FAIL wd_done got=%b want=%b", req_done, 4'b1 << r); end
    tick(); tick();
    total++; if (err_timeout !== 1'b1) begin bad++; $display("FAIL wd_sticky got=%b want=1", err_timeout); end
    m_last = r;
    $display("txn watchdog grant=%0d", r);
  endtask

  task automatic test_async_reset();
    int w;
    randomize_reqs();
    req_valid = 4'b0100;
    #1;
    tick();
    req_valid = '0;
    total++; if (grant_id !== 2'd2) begin bad++; $display("FAIL ar_grant got=%0d want=2", grant_id); end
    tick(); tick(); tick();
    #2;
    areset = 1'b1;
    #1;
    total++; if ({busy, wm_start, err_timeout, grant_id} !== 5'b0) begin bad++; $display("FAIL ar_flags got=%b want=00000", {busy, wm_start, err_timeout, grant_id}); end
    total++; if (wm_addr !== '0 || wm_data !== '0 || req_done !== '0) begin bad++; $display("FAIL ar_data got=%h want=0", wm_addr); end
    tick();
    areset = 1'b0;
    m_last = N - 1;
    wm_done = 1'b1;
    tick();
    wm_done = 1'b0;
    total++; if (req_done !== 4'h0 || busy !== 1'b0) begin bad++; $display("FAIL ar_late_done got=%b busy=%b want=0000/0", req_done, busy); end
    req_valid = 4'b1100;
    w = winner(m_last, 4'b1100);
    #1;
    total++; if (req_ready !== (4'b1 << w)) begin bad++; $display("FAIL ar_ptr got=%b want=%b", req_ready, 4'b1 << w); end
    tick();
    req_valid = '0;
    tick(); tick();
    wm_done = 1'b1;
    tick();
    wm_done = 1'b0;
    total++; if (req_done !== (4'b1 << w)) begin bad++; $display("FAIL ar_done got=%b want=%b", req_done, 4'b1 << w); end
    $display("txn async reset then grant=%0d", w);
  endtask

  initial begin
    req_valid = '0; wm_done = 1'b0; areset = 1'b1;
    req_addr = '0; req_data = '0;
    test_reset();
    test_single();
    test_random();
    test_spurious();
    test_handoff();
    test_fairness();
    test_watchdog();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
